// File: rtl/noc_packet_injector.sv
// rtl/noc_packet_injector.sv - AXI-Stream NoC packet source replaying a memory block to consecutive destinations
module noc_packet_injector #(
  parameter int DATAW     = 512,
  parameter int DESTW     = 12,
  parameter int IDW       = 32,
  parameter int NUM_ROWS  = 64,
  parameter int MEM_ADDRW = 16,
  parameter int LENW      = 16,
  parameter int NDESTW    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_mode,
  input  logic [8:0]           cmd_rf_addr,
  input  logic [DESTW-1:0]     cmd_dest,
  input  logic [NDESTW-1:0]    cmd_dest_count,
  input  logic [MEM_ADDRW-1:0] cmd_src_addr,
  input  logic [LENW-1:0]      cmd_len,
  input  logic [IDW-1:0]       cmd_id,
  output logic                 mem_rd_en,
  output logic [MEM_ADDRW-1:0] mem_rd_addr,
  input  logic [DATAW-1:0]     mem_rd_data,
  output logic                 axis_m_tvalid,
  input  logic                 axis_m_tready,
  output logic [DATAW-1:0]     axis_m_tdata,
  output logic                 axis_m_tlast,
  output logic [IDW-1:0]       axis_m_tid,
  output logic [DESTW-1:0]     axis_m_tdest,
  output logic [NUM_ROWS+10:0] axis_m_tuser,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  localparam int USERW = 11 + NUM_ROWS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state;
  logic [1:0]           mode_q;
  logic [8:0]           rf_q;
  logic [DESTW-1:0]     dest_q;
  logic [NDESTW-1:0]    ndest_q;
  logic [MEM_ADDRW-1:0] src_q;
  logic [LENW-1:0]      len_q;
  logic [IDW-1:0]       id_q;
  logic [LENW-1:0]      w_q;
  logic [NDESTW-1:0]    d_q;

  // Header of the read in flight travels alongside it so the beat is complete when data lands.
  logic                 infl_q;
  logic [USERW-1:0]     infl_user_q;
  logic [DESTW-1:0]     infl_dest_q;

  logic [DATAW-1:0]     fifo_data [2];
  logic [USERW-1:0]     fifo_user [2];
  logic [DESTW-1:0]     fifo_dest [2];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           count_q;

  logic                 pop, rd_en, last_read, cmd_bad;
  logic [2:0]           occ;
  logic [NUM_ROWS-1:0]  row_sel;
  logic [USERW-1:0]     hdr_user;

  // A beat leaving this cycle frees its slot, which keeps TREADY=1 streaming at one beat per cycle.
  assign pop       = (count_q != 2'd0) && axis_m_tready;
  assign occ       = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};
  assign rd_en     = (state == S_RUN) && (occ < 3'd2);
  assign last_read = (w_q == len_q - LENW'(1)) && (d_q == ndest_q - NDESTW'(1));
  assign cmd_bad   = (cmd_mode == 2'b01) || ((cmd_mode == 2'b11) && (cmd_len > LENW'(NUM_ROWS)));
  assign row_sel   = NUM_ROWS'(1) << w_q;
  assign hdr_user  = (mode_q == 2'b11) ? {row_sel, 2'b11, rf_q} : {NUM_ROWS'(0), mode_q, 9'd0};

  assign mem_rd_en     = rd_en;
  assign mem_rd_addr   = src_q + MEM_ADDRW'(w_q);
  assign axis_m_tvalid = (count_q != 2'd0);
  assign axis_m_tlast  = axis_m_tvalid;
  assign axis_m_tdata  = fifo_data[rd_ptr];
  assign axis_m_tuser  = fifo_user[rd_ptr];
  assign axis_m_tdest  = fifo_dest[rd_ptr];
  assign axis_m_tid    = id_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      mode_q      <= '0;
      rf_q        <= '0;
      dest_q      <= '0;
      ndest_q     <= '0;
      src_q       <= '0;
      len_q       <= '0;
      id_q        <= '0;
      w_q         <= '0;
      d_q         <= '0;
      infl_q      <= 1'b0;
      infl_user_q <= '0;
      infl_dest_q <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_user[i] <= '0;
        fifo_dest[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      if (infl_q) begin
        fifo_data[wr_ptr] <= mem_rd_data;
        fifo_user[wr_ptr] <= infl_user_q;
        fifo_dest[wr_ptr] <= infl_dest_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count_q <= count_q + {1'b0, infl_q} - {1'b0, pop};

      infl_q <= rd_en;
      if (rd_en) begin
        infl_user_q <= hdr_user;
        infl_dest_q <= dest_q + DESTW'(d_q);
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_bad) begin
              err <= 1'b1;
            end else begin
              mode_q    <= cmd_mode;
              rf_q      <= cmd_rf_addr;
              dest_q    <= cmd_dest;
              ndest_q   <= (cmd_dest_count == '0) ? NDESTW'(1) : cmd_dest_count;
              src_q     <= cmd_src_addr;
              len_q     <= cmd_len;
              id_q      <= cmd_id;
              w_q       <= '0;
              d_q       <= '0;
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
              if (cmd_len == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_RUN;
              end
            end
          end
        end
        S_RUN: begin
          if (rd_en) begin
            if (w_q == len_q - LENW'(1)) begin
              w_q <= '0;
              d_q <= d_q + NDESTW'(1);
            end else begin
              w_q <= w_q + LENW'(1);
            end
            if (last_read) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && (count_q == 2'd1) && !infl_q) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_noc_packet_injector.sv
// tb/tb_noc_packet_injector.sv - scoreboard bench for noc_packet_injector with a behavioural packet model
module tb_noc_packet_injector;
  localparam int DATAW = 64, DESTW = 12, IDW = 32, NUM_ROWS = 64;
  localparam int MEM_ADDRW = 8, LENW = 16, NDESTW = 8;
  localparam int USERW = 11 + NUM_ROWS;
  localparam int MEMSZ = 1 << MEM_ADDRW;

  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_mode = '0;
  logic [8:0] cmd_rf_addr = '0;
  logic [DESTW-1:0] cmd_dest = '0;
  logic [NDESTW-1:0] cmd_dest_count = '0;
  logic [MEM_ADDRW-1:0] cmd_src_addr = '0;
  logic [LENW-1:0] cmd_len = '0;
  logic [IDW-1:0] cmd_id = '0;
  logic mem_rd_en;
  logic [MEM_ADDRW-1:0] mem_rd_addr;
  logic [DATAW-1:0] mem_rd_data = '0;
  logic axis_m_tvalid, axis_m_tready, axis_m_tlast;
  logic [DATAW-1:0] axis_m_tdata;
  logic [IDW-1:0] axis_m_tid;
  logic [DESTW-1:0] axis_m_tdest;
  logic [USERW-1:0] axis_m_tuser;
  logic busy, done, err;

  noc_packet_injector #(.DATAW(DATAW), .DESTW(DESTW), .IDW(IDW), .NUM_ROWS(NUM_ROWS),
                        .MEM_ADDRW(MEM_ADDRW), .LENW(LENW), .NDESTW(NDESTW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_rf_addr(cmd_rf_addr), .cmd_dest(cmd_dest), .cmd_dest_count(cmd_dest_count),
    .cmd_src_addr(cmd_src_addr), .cmd_len(cmd_len), .cmd_id(cmd_id), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .axis_m_tvalid(axis_m_tvalid),
    .axis_m_tready(axis_m_tready), .axis_m_tdata(axis_m_tdata), .axis_m_tlast(axis_m_tlast),
    .axis_m_tid(axis_m_tid), .axis_m_tdest(axis_m_tdest), .axis_m_tuser(axis_m_tuser),
    .busy(busy), .done(done), .err(err));

  initial forever #5 clk = ~clk;

  logic [DATAW-1:0] mem [MEMSZ];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  typedef struct {
    logic [DATAW-1:0] data;
    logic [USERW-1:0] user;
    logic [DESTW-1:0] dest;
    logic [IDW-1:0]   id;
  } beat_t;

  beat_t exp_q[$];
  int hs_cyc_q[$];
  int n_checks = 0, n_pass = 0;
  int cyc = 0, last_hs_cyc = 0;
  int reads_issued = 0, beats_acc = 0, beats_seen = 0;
  int done_pulses = 0, err_pulses = 0, exp_dones = 0, exp_errs = 0;
  int tready_mode = 0, tr_t = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: every destination pass re-reads the same block; the row bit follows the word index.
  task automatic model_cmd(input logic [1:0] mode, input logic [8:0] rf, input int dest, input int ndest,
                           input int src, input int len, input logic [IDW-1:0] id);
    int nd;
    beat_t b;
    nd = (ndest == 0) ? 1 : ndest;
    for (int d = 0; d < nd; d++) begin
      for (int w = 0; w < len; w++) begin
        b.data = mem[(src + w) % MEMSZ];
        b.dest = DESTW'((dest + d) % (1 << DESTW));
        b.id   = id;
        if (mode == 2'b11) b.user = (USERW'(1) << (11 + w)) | (USERW'(3) << 9) | USERW'(rf);
        else if (mode == 2'b10) b.user = USERW'(2) << 9;
        else b.user = '0;
        exp_q.push_back(b);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      reads_issued = 0;
      beats_acc = 0;
    end else begin
      if (mem_rd_en)
        chk("rd_occupancy", ((reads_issued - beats_acc - int'(axis_m_tvalid && axis_m_tready)) < 2), 1);
      if (mem_rd_en) reads_issued++;
      if (axis_m_tvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          chk("tdata", axis_m_tdata, exp_q[0].data);
          chk("tuser", axis_m_tuser, exp_q[0].user);
          chk("tdest", axis_m_tdest, exp_q[0].dest);
          chk("tid", axis_m_tid, exp_q[0].id);
          chk("tlast", axis_m_tlast, 1);
          if (axis_m_tready) begin
            void'(exp_q.pop_front());
            beats_acc++;
            beats_seen++;
            hs_cyc_q.push_back(cyc);
            last_hs_cyc = cyc;
          end
        end
      end
      if (done) done_pulses++;
      if (err) err_pulses++;
    end
  end

  initial begin
    axis_m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      tr_t++;
      case (tready_mode)
        0: axis_m_tready = 1'b1;
        1: axis_m_tready = ($urandom_range(0, 3) != 0);
        default: axis_m_tready = (tr_t >= 6 && tr_t < 11) ? 1'b0 : (tr_t % 2 == 0);
      endcase
    end
  end

  task automatic set_tready(input int m);
    @(negedge clk);
    tready_mode = m;
    tr_t = 0;
  endtask

  task automatic drive_cmd(input logic [1:0] mode, input logic [8:0] rf, input int dest, input int ndest,
                           input int src, input int len, input logic [IDW-1:0] id);
    cmd_valid = 1'b1;
    cmd_mode = mode;
    cmd_rf_addr = rf;
    cmd_dest = DESTW'(dest);
    cmd_dest_count = NDESTW'(ndest);
    cmd_src_addr = MEM_ADDRW'(src);
    cmd_len = LENW'(len);
    cmd_id = id;
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] mode, input logic [8:0] rf, input int dest,
                         input int ndest, input int src, input int len, input logic [IDW-1:0] id,
                         output int hs, output int dcyc);
    int t0_reads, t0_beats, nbeats;
    bit bad, got;
    bad = (mode == 2'b01) || (mode == 2'b11 && len > NUM_ROWS);
    nbeats = bad ? 0 : len * ((ndest == 0) ? 1 : ndest);
    dcyc = -1;
    @(posedge clk); #1;
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    drive_cmd(mode, rf, dest, ndest, src, len, id);
    hs = cyc;
    t0_reads = reads_issued;
    t0_beats = beats_seen;
    if (!bad) model_cmd(mode, rf, dest, ndest, src, len, id);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (bad) begin
      exp_errs++;
      @(negedge clk);
      chk({tag, "_err_pulse"}, err, 1);
      chk({tag, "_err_no_done"}, done, 0);
      @(negedge clk);
      chk({tag, "_err_one_cycle"}, err, 0);
      repeat (4) @(negedge clk);
      chk({tag, "_err_no_reads"}, reads_issued - t0_reads, 0);
      chk({tag, "_err_no_beats"}, beats_seen - t0_beats, 0);
      chk({tag, "_err_idle"}, cmd_ready, 1);
    end else begin
      exp_dones++;
      got = 0;
      for (int i = 0; i < nbeats * 8 + 40 && !got; i++) begin
        @(negedge clk);
        if (done) begin
          got = 1;
          dcyc = cyc;
        end
      end
      chk({tag, "_done_seen"}, got, 1);
      if (got) begin
        chk({tag, "_beat_count"}, beats_seen - t0_beats, nbeats);
        chk({tag, "_scoreboard_empty"}, exp_q.size(), 0);
        chk({tag, "_done_cycle"}, dcyc, (nbeats == 0) ? hs + 1 : last_hs_cyc + 1);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_ready_after_done"}, cmd_ready, 1);
      end
    end
  endtask

  initial begin
    int hs, dcyc, t0, d0;
    bit reached;
    for (int i = 0; i < MEMSZ; i++) mem[i] = {$urandom, $urandom};
    tready_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_tvalid", axis_m_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_fields", {axis_m_tdata, axis_m_tuser, axis_m_tdest, axis_m_tid, axis_m_tlast, mem_rd_addr}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    hs_cyc_q.delete();
    run_cmd("w4", 2'b11, 9'd1, 1, 1, 16, 4, 32'hA5A50001, hs, dcyc);
    chk("w4_hs_count", hs_cyc_q.size(), 4);
    for (int i = 0; i < hs_cyc_q.size(); i++) chk("w4_beat_cycle", hs_cyc_q[i], hs + 3 + i);
    chk("w4_done_abs", dcyc, hs + 7);

    run_cmd("w64x2", 2'b11, 9'd2, 1, 2, 240, 64, 32'h00000064, hs, dcyc);
    run_cmd("ivec", 2'b10, 9'h1FF, 5, 1, 7, 1, 32'h11, hs, dcyc);
    run_cmd("inst", 2'b00, 9'h1FF, 6, 1, 9, 1, 32'h22, hs, dcyc);

    set_tready(2);
    run_cmd("stall8", 2'b11, 9'd3, 12'hFFE, 1, 100, 8, 32'h88, hs, dcyc);
    set_tready(0);

    run_cmd("mode01", 2'b01, 9'd0, 3, 1, 0, 4, 32'h1, hs, dcyc);
    run_cmd("w65", 2'b11, 9'd0, 3, 1, 0, 65, 32'h2, hs, dcyc);
    run_cmd("len0", 2'b10, 9'd0, 3, 1, 0, 0, 32'h3, hs, dcyc);

    @(posedge clk); #1;
    drive_cmd(2'b11, 9'd4, 9, 1, 50, 10, 32'hDEAD);
    model_cmd(2'b11, 9'd4, 9, 1, 50, 10, 32'hDEAD);
    t0 = beats_seen;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    reached = 0;
    for (int i = 0; i < 60 && !reached; i++) begin
      @(negedge clk);
      if (beats_seen - t0 >= 3) reached = 1;
    end
    chk("rst_mid_reached_beat3", reached, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_tvalid", axis_m_tvalid, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    chk("rst_mid_busy", busy, 0);
    exp_q.delete();
    d0 = done_pulses;
    repeat (6) @(negedge clk);
    chk("rst_mid_no_done", done_pulses - d0, 0);
    chk("rst_mid_no_beats", axis_m_tvalid, 0);
    run_cmd("after_rst", 2'b11, 9'd5, 20, 1, 60, 2, 32'hBEEF, hs, dcyc);

    set_tready(1);
    for (int k = 0; k < 14; k++) begin
      logic [1:0] m;
      int len;
      m = 2'($urandom_range(0, 3));
      len = (m == 2'b11) ? $urandom_range(0, 70) : $urandom_range(0, 8);
      run_cmd("rand", m, 9'($urandom), $urandom_range(0, 4095), $urandom_range(0, 3),
              $urandom_range(0, MEMSZ - 1), len, $urandom, hs, dcyc);
    end
    set_tready(0);

    repeat (4) @(negedge clk);
    chk("done_total", done_pulses, exp_dones);
    chk("err_total", err_pulses, exp_errs);
    chk("final_scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, checks %0d passed %0d", n_checks, n_pass);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/noc_packet_injector.md
Name: noc_packet_injector

Overview:
- Synthesizable AXI-Stream packet source that replaces hand-scripted NoC stimulus.
- Accepts one command, fetches DATAW-bit words from a local word memory, and emits one single-beat NoC packet per word in the MVM tuser format:
  - tuser[8:0]: RF address.
  - tuser[10:9]: opcode.
  - tuser[11+r]: one-hot row select.
- Generalised over row count, data/dest/user widths and mode.
- Can replay the same block to a run of consecutive destinations, so one weight set can be broadcast to several MVMs.
- Sits between a host/control FSM and the NoC ingress AXIS_S port of mvm_top.

Parameters:
- DATAW, 512: payload width.
- DESTW, 12: NoC destination width.
- IDW, 32: TID width.
- NUM_ROWS, 64: one-hot row-select bits. USERW is derived as 11+NUM_ROWS (default 75).
- MEM_ADDRW, 16: source memory address width.
- LENW, 16: word-count width.
- NDESTW, 8: destination-count width.

Ports:
- CLK, in, 1: single clock.
- RST, in, 1: synchronous reset, active-high.
- CMD_VALID, in, 1: command valid.
- CMD_READY, out, 1: command ready. High only in IDLE.
- CMD_MODE, in, 2: opcode. 2'b00 = instruction, 2'b10 = input vector, 2'b11 = weights. 2'b01 is illegal.
- CMD_RF_ADDR, in, 9: RF address. Used in weight mode only.
- CMD_DEST, in, DESTW: first destination.
- CMD_DEST_COUNT, in, NDESTW: number of destinations. 0 is treated as 1.
- CMD_SRC_ADDR, in, MEM_ADDRW: first memory word.
- CMD_LEN, in, LENW: words per destination.
- CMD_ID, in, IDW: tag copied to TID.
- MEM_RD_EN, out, 1: memory read strobe.
- MEM_RD_ADDR, out, MEM_ADDRW: read address.
- MEM_RD_DATA, in, DATAW: read data, valid exactly 1 cycle after MEM_RD_EN.
- AXIS_M_TVALID, out, 1: beat valid.
- AXIS_M_TREADY, in, 1: beat ready.
- AXIS_M_TDATA, out, DATAW: beat data.
- AXIS_M_TLAST, out, 1: last flag.
- AXIS_M_TID, out, IDW: command tag.
- AXIS_M_TDEST, out, DESTW: destination.
- AXIS_M_TUSER, out, 11+NUM_ROWS: packet header.
- BUSY, out, 1: high when not in IDLE.
- DONE, out, 1: one-cycle completion pulse.
- ERR, out, 1: one-cycle rejection pulse.

Behaviour:
- Reset values: CMD_READY=1, all other outputs 0, state IDLE, counters and buffer cleared.
- RST asserted mid-command:
  - Aborts the command on the next edge.
  - Discards any in-flight memory read.
  - TVALID is low the cycle after RST is sampled.
  - No DONE pulse.
- States:
  - IDLE: CMD_READY=1. On CMD_VALID, latch the command and go to RUN. The error and zero-length cases below override this.
  - RUN: issue reads and emit beats. After the last read has been issued, go to DRAIN.
  - DRAIN: wait for buffered beats to be accepted. After the final handshake, go to DONE.
  - DONE: pulse DONE=1 for one cycle, then IDLE.
- Rejection:
  - Command with MODE=2'b01, or weight mode with LEN>NUM_ROWS, is rejected.
  - Rejection is a handshake only: ERR pulses on the next cycle, no reads, no beats, stays IDLE.
- LEN=0: handshake, then DONE on the next cycle; no reads, no beats.
- Counters:
  - Word index w runs 0..LEN-1; destination index d runs 0..DEST_COUNT-1.
  - w wraps to 0 and d increments after each pass.
  - Each pass re-reads from SRC_ADDR.
  - MEM_RD_ADDR = SRC_ADDR + w, modulo 2^MEM_ADDRW.
- Buffering:
  - 2-entry output FIFO.
  - A read is issued only when occupied entries plus in-flight reads < 2.
  - Each beat stores its data together with its header fields.
  - With TREADY held high, throughput is 1 beat/cycle.
  - No beat is dropped or duplicated under any TREADY pattern.
- Latency: first TVALID is asserted 3 cycles after the command handshake cycle. The handshake is in cycle N, the read in N+1, data in N+2, TVALID in N+3.
- AXIS rule: once TVALID=1, the beat and all its sideband fields are stable until TREADY=1.
- Beat fields:
  - TLAST=1 on every beat (single-beat packets).
  - TID=CMD_ID.
  - TDEST=CMD_DEST+d, modulo 2^DESTW.
- TUSER by mode:
  - Weights: [8:0]=RF_ADDR, [10:9]=2'b11, bit 11+w set, all other row bits 0.
  - Input vector: [8:0]=0, [10:9]=2'b10, row bits 0.
  - Instruction: [8:0]=0, [10:9]=2'b00, row bits 0.
- DONE timing: DONE is asserted the cycle after the handshake of the final beat (LEN*DEST_COUNT beats total).
- A new command cannot be accepted before the cycle after DONE.

Test Plan:
- Weights, LEN=4, DEST=0x001, DEST_COUNT=1, RF=1, TREADY=1:
  - 4 beats on consecutive cycles, first at handshake+3.
  - TUSER bits 11,12,13,14 set in turn; [10:9]=11; [8:0]=1.
  - DONE pulses the cycle after beat 4.
- Weights, LEN=64, DEST_COUNT=2, RF=2:
  - 128 beats.
  - Beats 0-63 have TDEST=0x001, beats 64-127 have TDEST=0x002.
  - Data repeats; row bit 11+63 is set on beats 63 and 127.
- Input vector, LEN=1, then instruction, LEN=1:
  - Beat 1: TUSER[10:9]=10, row bits 0.
  - Beat 2: TUSER[10:9]=00, TDATA equals memory word.
- Weights, LEN=8, TREADY toggling 1010... and held low for 5 cycles mid-stream:
  - Exactly 8 beats, in order, fields stable while stalled.
  - MEM_RD_EN never issues with 2 entries occupied or in flight.
- Error cases:
  - MODE=01 -> ERR pulse, no beats.
  - Weights with LEN=65 -> ERR pulse, no beats.
  - LEN=0 -> DONE the cycle after handshake, no beats.
- RST mid-command: assert RST after beat 3 of LEN=10 -> TVALID=0 the next cycle, CMD_READY=1, no DONE; a new LEN=2 command then completes normally.
